// File: rtl/mux_tree_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined mux tree.
package mux_pkg;
   localparam int MAX_CH = 256;

   function automatic int clog4(input int n);
      int r = 0;
      for (int v = 1; v < n; v = v * 4) r++;
      return r;
   endfunction

   function automatic bit is_pow4(input int n);
      return (n >= 4) && (n <= MAX_CH) && ((1 << (2 * clog4(n))) == n);
   endfunction

   // Index of the first node of level l when all levels are laid out flat.
   function automatic int lvl_off(input int ch, input int l);
      int o = 0;
      for (int i = 0; i < l; i++) o += ch >> (2 * (i + 1));
      return o;
   endfunction
endpackage

// File: rtl/mux_tree_pipe_if.sv
// Source/consumer bundle of the pipelined mux tree; master drives the inputs.
interface mux_tree_pipe_if #(
   parameter int DATA_W = 8,
   parameter int CH     = 16,
   parameter int SEL_W  = $clog2(CH)
);
   logic [CH*DATA_W-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [SEL_W-1:0]     sel;
   logic                 scan_en;
   logic [DATA_W-1:0]    out_data;
   logic [SEL_W-1:0]     out_ch;
   logic                 out_valid;
   logic                 out_ready;
   logic [SEL_W-1:0]     scan_ptr;

   modport master (
      output in_data, in_valid, sel, scan_en, out_ready,
      input  in_ready, out_data, out_ch, out_valid, scan_ptr
   );
   modport slave (
      input  in_data, in_valid, sel, scan_en, out_ready,
      output in_ready, out_data, out_ch, out_valid, scan_ptr
   );
endinterface

// File: rtl/mux_tree_pipe_mux4_stage.sv
// One registered 4:1 node of the tree; holds its output while en is low.
module mux4_stage #(
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [3:0][DATA_W-1:0] d,
   input  logic [1:0]             s,
   output logic [DATA_W-1:0]      q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (en) q <= d[s];
   end
endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined CH:1 mux built from registered 4:1 levels, with valid/ready and auto-scan.
module mux_tree_pipe import mux_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int CH     = 16,
   parameter int SEL_W  = $clog2(CH),
   parameter int LEVELS = clog4(CH)
) (
   input logic            clk,
   input logic            rst,
   mux_tree_pipe_if.slave bus
);
   localparam int NODES = lvl_off(CH, LEVELS);

   if (!is_pow4(CH) || SEL_W != 2 * LEVELS) begin : g_bad_ch
      $error("mux_tree_pipe: CH must be a power of 4 in 4..256");
   end

   logic                         stall, acc;
   logic [SEL_W-1:0]             eff_sel, scan_ptr;
   logic [LEVELS:1]              vld_pipe;
   logic [LEVELS:1][SEL_W-1:0]   ch_pipe;
   logic [NODES-1:0][DATA_W-1:0] nq;

   // Whole pipeline freezes on a stalled output; no bubble collapsing.
   assign stall        = vld_pipe[LEVELS] && !bus.out_ready;
   assign acc          = bus.in_valid && !stall;
   assign eff_sel      = bus.scan_en ? scan_ptr : bus.sel;
   assign bus.in_ready = !stall;

   // CH is a power of two, so the natural counter wrap gives CH-1 -> 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      scan_ptr <= '0;
      else if (acc && bus.scan_en)  scan_ptr <= scan_ptr + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         ch_pipe  <= '0;
      end else if (!stall) begin
         vld_pipe[1] <= acc;
         ch_pipe[1]  <= eff_sel;
         for (int l = 2; l <= LEVELS; l++) begin
            vld_pipe[l] <= vld_pipe[l-1];
            ch_pipe[l]  <= ch_pipe[l-1];
         end
      end
   end

   // Level l consumes select bits [2l+1:2l] of the select captured with the beat.
   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int NN  = CH >> (2 * (l + 1));
      localparam int OFF = lvl_off(CH, l);
      logic [1:0] s;
      if (l == 0) begin : g_s
         assign s = eff_sel[1:0];
      end else begin : g_s
         assign s = ch_pipe[l][2*l+1:2*l];
      end
      for (genvar n = 0; n < NN; n++) begin : g_node
         logic [3:0][DATA_W-1:0] d;
         if (l == 0) begin : g_d
            assign d = bus.in_data[4*n*DATA_W +: 4*DATA_W];
         end else begin : g_d
            assign d = nq[lvl_off(CH, l - 1) + 4*n +: 4];
         end
         mux4_stage #(.DATA_W(DATA_W)) u_node (
            .clk (clk),
            .rst (rst),
            .en  (!stall),
            .d   (d),
            .s   (s),
            .q   (nq[OFF+n])
         );
      end
   end

   assign bus.out_data  = nq[NODES-1];
   assign bus.out_ch    = ch_pipe[LEVELS];
   assign bus.out_valid = vld_pipe[LEVELS];
   assign bus.scan_ptr  = scan_ptr;
endmodule
